// File: rtl/ecall_console_if.sv
// Core/console-side bundle of the ECALL service unit.
// Byte stream: a byte transfers on a rising edge where char_valid && char_ready; once
// char_valid rises, char_data holds steady and char_valid stays high until that transfer.
interface ecall_console_if;
  logic        ecall_valid;
  logic [31:0] a0;
  logic [31:0] a1;
  logic        stall;
  logic        halted;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [2:0]  dbg_state;

  modport slave (
    input  ecall_valid, a0, a1, char_ready,
    output stall, halted, char_valid, char_data, dbg_state
  );

  modport master (
    output ecall_valid, a0, a1, char_ready,
    input  stall, halted, char_valid, char_data, dbg_state
  );
endinterface

// File: rtl/ecall_console.sv
// ECALL service unit: stalls the core, prints a1 as signed decimal (a0==1) over a byte
// stream, or halts the core for good (a0==10).
module ecall_console #(
  parameter logic [7:0]  NEWLINE    = 8'h0A,
  parameter logic [31:0] HALT_CODE  = 32'd10,
  parameter logic [31:0] PRINT_CODE = 32'd1
) (
  input  logic              clock,
  input  logic              reset,
  ecall_console_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CONV  = 3'd1,
    S_SIGN  = 3'd2,
    S_DIGIT = 3'd3,
    S_NL    = 3'd4,
    S_DONE  = 3'd5,
    S_HALT  = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic        neg_q, neg_d;
  logic [31:0] mag_q, mag_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        char_valid_q, char_valid_d;
  logic [7:0]  char_data_q, char_data_d;

  logic        stall;
  logic [39:0] bcd_adj;
  logic [39:0] bcd_shift;
  logic [31:0] mag_shift;
  logic [3:0]  ptr_calc;

  function automatic logic [39:0] bcd_adjust(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] digit_char(input logic [39:0] b, input logic [3:0] p);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (p == 4'(i)) d = b[i*4 +: 4];
    end
    return 8'h30 + {4'h0, d};
  endfunction

  // One double-dabble step and the leading-digit position of its result.
  always_comb begin
    bcd_adj = bcd_adjust(bcd_q);
    {bcd_shift, mag_shift} = {bcd_adj, mag_q} << 1;
    ptr_calc = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bcd_shift[i*4 +: 4] != 4'd0) ptr_calc = 4'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    neg_d        = neg_q;
    mag_d        = mag_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    char_valid_d = char_valid_q;
    char_data_d  = char_data_q;
    stall        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.ecall_valid && bus.a0 == HALT_CODE) begin
          stall   = 1'b1;
          state_d = S_HALT;
        end else if (bus.ecall_valid && bus.a0 == PRINT_CODE) begin
          stall   = 1'b1;
          state_d = S_CONV;
          neg_d   = bus.a1[31];
          mag_d   = bus.a1[31] ? (~bus.a1 + 32'd1) : bus.a1;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      S_CONV: begin
        stall = 1'b1;
        bcd_d = bcd_shift;
        mag_d = mag_shift;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          ptr_d        = ptr_calc;
          char_valid_d = 1'b1;
          if (neg_q) begin
            state_d     = S_SIGN;
            char_data_d = 8'h2D;
          end else begin
            state_d     = S_DIGIT;
            char_data_d = digit_char(bcd_shift, ptr_calc);
          end
        end
      end
      S_SIGN: begin
        stall = 1'b1;
        if (bus.char_ready) begin
          state_d     = S_DIGIT;
          char_data_d = digit_char(bcd_q, ptr_q);
        end
      end
      S_DIGIT: begin
        stall = 1'b1;
        if (bus.char_ready) begin
          if (ptr_q != 4'd0) begin
            ptr_d       = ptr_q - 4'd1;
            char_data_d = digit_char(bcd_q, ptr_q - 4'd1);
          end else begin
            state_d     = S_NL;
            char_data_d = NEWLINE;
          end
        end
      end
      S_NL: begin
        stall = 1'b1;
        if (bus.char_ready) begin
          state_d      = S_DONE;
          char_valid_d = 1'b0;
          char_data_d  = 8'h00;
        end
      end
      // Core retires the ECALL on this edge; a still-high ecall_valid is not a new call.
      S_DONE: state_d = S_IDLE;
      S_HALT: stall = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      neg_q        <= 1'b0;
      mag_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      char_valid_q <= 1'b0;
      char_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      neg_q        <= neg_d;
      mag_q        <= mag_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
    end
  end

  assign bus.stall      = stall;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.char_valid = char_valid_q;
  assign bus.char_data  = char_data_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_ecall_console.sv
// Self-checking bench for ecall_console: decimal strings come from an arithmetic model.
module tb_ecall_console;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ecall_console_if bus();

  ecall_console dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         first_valid_k;
  int         done_k;
  int         unstable;
  int         hold_seen;
  logic       done_valid;
  logic       accept_stall;
  logic       timeout;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected byte stream: optional '-', decimal digits of |v|, newline.
  function automatic void model(input logic [31:0] v);
    longint s;
    logic [7:0] tmp[$];
    exp_q.delete();
    s = longint'($signed(v));
    if (s < 0) begin
      exp_q.push_back(8'h2D);
      s = -s;
    end
    do begin
      tmp.push_front(8'(48 + s % 10));
      s = s / 10;
    end while (s > 0);
    foreach (tmp[i]) exp_q.push_back(tmp[i]);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic idle_inputs();
    bus.ecall_valid = 1'b0;
    bus.a0          = 32'd0;
    bus.a1          = 32'd0;
    bus.char_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // mode 0: sink always ready; 1: random ready; 2: ready low 5 cycles on the second byte.
  task automatic run_print(input logic [31:0] v, input int mode);
    int k;
    logic pend;
    logic [7:0] pdata;
    int nbyte;
    int hold;
    logic rdy;
    got_q.delete();
    first_valid_k = -1;
    done_k = -1;
    unstable = 0;
    hold_seen = 0;
    done_valid = 1'b0;
    timeout = 1'b0;
    pend = 1'b0;
    pdata = 8'h00;
    nbyte = 0;
    hold = 0;
    bus.ecall_valid = 1'b1;
    bus.a0 = 32'd1;
    bus.a1 = v;
    bus.char_ready = 1'b0;
    #1 accept_stall = bus.stall;
    @(posedge clock);
    #1;
    k = 0;
    while (k < 300) begin
      if (!bus.stall) begin
        done_k = k;
        done_valid = bus.char_valid;
        break;
      end
      if (pend && (!bus.char_valid || bus.char_data !== pdata)) unstable++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(nbyte == 1 && hold < 5);
      endcase
      if (bus.char_valid) begin
        if (first_valid_k < 0) first_valid_k = k;
        if (mode == 2 && !rdy) begin
          hold++;
          if (bus.char_data === 8'h30) hold_seen++;
        end
        if (rdy) begin
          got_q.push_back(bus.char_data);
          nbyte++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          pdata = bus.char_data;
        end
      end
      bus.char_ready = rdy;
      @(posedge clock);
      #1;
      k++;
    end
    if (done_k < 0) timeout = 1'b1;
    bus.ecall_valid = 1'b0;
    bus.char_ready = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
    n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL reset_char_valid: got %b expected 0", bus.char_valid); end
    n_checks++; if (bus.char_data !== 8'h00) begin n_fail++; $display("FAIL reset_char_data: got %h expected 00", bus.char_data); end
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_print_values();
    logic [31:0] vals[5];
    logic [7:0] g;
    vals = '{32'd42, 32'hFFFFFFF9, 32'd0, 32'h80000000, 32'h7FFFFFFF};
    foreach (vals[n]) begin
      model(vals[n]);
      run_print(vals[n], 0);
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL print_timeout[%0d]: got 1 expected 0", n); end
      n_checks++; if (accept_stall !== 1'b1) begin n_fail++; $display("FAIL print_accept_stall[%0d]: got %b expected 1", n, accept_stall); end
      n_checks++; if (first_valid_k != 32) begin n_fail++; $display("FAIL print_latency[%0d]: got %0d expected 32", n, first_valid_k); end
      n_checks++; if (done_k != 32 + exp_q.size()) begin n_fail++; $display("FAIL print_done_cycle[%0d]: got %0d expected %0d", n, done_k, 32 + exp_q.size()); end
      n_checks++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL print_done_valid[%0d]: got %b expected 0", n, done_valid); end
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL print_len[%0d]: got %0d expected %0d", n, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        g = (i < got_q.size()) ? got_q[i] : 8'hFF;
        n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL print_byte[%0d][%0d]: got %h expected %h", n, i, g, exp_q[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] g;
    model(32'd1000);
    run_print(32'd1000, 2);
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got 1 expected 0"); end
    n_checks++; if (hold_seen != 5) begin n_fail++; $display("FAIL bp_hold_data: got %0d cycles of 30 expected 5", hold_seen); end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stability: got %0d violations expected 0", unstable); end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hFF;
      n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte[%0d]: got %h expected %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [7:0] g;
    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 2))
        0:       v = $urandom;
        1:       v = 32'($urandom_range(0, 99));
        default: v = -32'($urandom_range(1, 99999));
      endcase
      model(v);
      run_print(v, 1);
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rand_timeout[%0d]: got 1 expected 0 (a1=%h)", n, v); end
      n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL rand_stability[%0d]: got %0d expected 0", n, unstable); end
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_len[%0d]: got %0d expected %0d (a1=%h)", n, got_q.size(), exp_q.size(), v); end
      for (int i = 0; i < exp_q.size(); i++) begin
        g = (i < got_q.size()) ? got_q[i] : 8'hFF;
        n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte[%0d][%0d]: got %h expected %h (a1=%h)", n, i, g, exp_q[i], v); end
      end
    end
  endtask

  task automatic test_halt();
    bus.ecall_valid = 1'b1;
    bus.a0 = 32'd10;
    bus.a1 = $urandom;
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL halt_req_stall: got %b expected 1", bus.stall); end
    @(posedge clock);
    #1;
    for (int c = 0; c < 16; c++) begin
      n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted[%0d]: got %b expected 1", c, bus.halted); end
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL halt_stall[%0d]: got %b expected 1", c, bus.stall); end
      n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL halt_char_valid[%0d]: got %b expected 0", c, bus.char_valid); end
      bus.ecall_valid = 1'($urandom_range(0, 1));
      bus.a0 = $urandom_range(0, 1) ? 32'd1 : 32'd10;
      bus.a1 = $urandom;
      bus.char_ready = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
    end
    do_reset();
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_cleared: got %b expected 0", bus.halted); end
  endtask

  task automatic test_unsupported();
    logic [31:0] codes[5];
    codes = '{32'd5, 32'd0, 32'd2, 32'd11, 32'($urandom_range(12, 100000))};
    foreach (codes[n]) begin
      bus.ecall_valid = 1'b1;
      bus.a0 = codes[n];
      bus.a1 = $urandom;
      bus.char_ready = 1'b1;
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL unsup_stall[%0d]: got %b expected 0 (a0=%0d)", n, bus.stall, codes[n]); end
      @(posedge clock);
      #1;
      n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL unsup_char_valid[%0d]: got %b expected 0", n, bus.char_valid); end
      n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL unsup_halted[%0d]: got %b expected 0", n, bus.halted); end
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL unsup_stall_next[%0d]: got %b expected 0", n, bus.stall); end
      idle_inputs();
    end
  endtask

  task automatic test_reset_mid();
    int k;
    logic [7:0] g;
    // Reset during conversion.
    bus.ecall_valid = 1'b1;
    bus.a0 = 32'd1;
    bus.a1 = 32'd987654;
    bus.char_ready = 1'b1;
    repeat (10) @(posedge clock);
    #3;
    idle_inputs();
    reset = 1'b1;
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_conv_stall: got %b expected 0", bus.stall); end
    n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL rst_conv_char_valid: got %b expected 0", bus.char_valid); end
    @(posedge clock);
    #1 reset = 1'b0;
    // Reset while digits are streaming.
    bus.ecall_valid = 1'b1;
    bus.a0 = 32'd1;
    bus.a1 = 32'd987654;
    bus.char_ready = 1'b1;
    k = 0;
    @(posedge clock);
    #1;
    while (!bus.char_valid && k < 40) begin
      @(posedge clock);
      #1;
      k++;
    end
    @(posedge clock);
    #1;
    n_checks++; if (bus.char_valid !== 1'b1) begin n_fail++; $display("FAIL rst_digit_reached: got %b expected 1", bus.char_valid); end
    #3;
    idle_inputs();
    reset = 1'b1;
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_digit_stall: got %b expected 0", bus.stall); end
    n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL rst_digit_char_valid: got %b expected 0", bus.char_valid); end
    n_checks++; if (bus.char_data !== 8'h00) begin n_fail++; $display("FAIL rst_digit_char_data: got %h expected 00", bus.char_data); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL rst_digit_halted: got %b expected 0", bus.halted); end
    @(posedge clock);
    #1 reset = 1'b0;
    model(32'd9);
    run_print(32'd9, 0);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rst_fresh_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hFF;
      n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL rst_fresh_byte[%0d]: got %h expected %h", i, g, exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_print_values();
    test_backpressure();
    test_unsupported();
    test_random();
    test_reset_mid();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
